// File: rtl/phase_shift_gen.sv
// phase_shift_gen: N_CH square-wave dividers, each able to stretch or shrink one half-period on command.
// Define PHASE_TRACK_EN to build the per-channel signed cumulative-shift accumulators on phase_acc.
module phase_shift_gen #(
  parameter int N_CH = 2,
  parameter int CNT_W = 16,
  parameter int STEP_W = 16,
  parameter int unsigned HALF_PERIOD_DEF = 4999,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [CNT_W-1:0] half_period,
  input  logic sync_req,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic cmd_dir,
  input  logic [STEP_W-1:0] cmd_step,
  output logic [N_CH-1:0] mod_out,
  output logic [N_CH-1:0] shift_done,
  output logic [N_CH*(CNT_W+2)-1:0] phase_acc
);
  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;
  localparam logic [CNT_W-1:0] H_DEF = CNT_W'(HALF_PERIOD_DEF);
  logic [N_CH-1:0] idle;
  always_comb begin
    cmd_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) cmd_ready = cmd_ready | (idle[i] & (cmd_ch == CH_W'(i)));
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t st, st_nxt;
    logic [CNT_W-1:0] cnt, term, term_nxt, step_x, eff;
    logic [STEP_W-1:0] step;
    logic dir, mod, hit, accept, sat;
    assign hit = cnt == term;
    assign accept = cmd_valid & cmd_ready & (cmd_ch == CH_W'(c));
    assign step_x = CNT_W'(step);
    // H+step overflows exactly when step exceeds the headroom ~H = max-H
    assign sat = step_x > ~half_period;
    assign eff = dir ? (sat ? ~half_period : step_x) : (step_x > half_period ? half_period : step_x);
    assign idle[c] = st == IDLE;
    assign mod_out[c] = mod;
    assign shift_done[c] = st == APPLY && hit && !sync_req;
    always_comb begin
      st_nxt = st;
      term_nxt = hit ? half_period : term;
      if (sync_req) begin
        st_nxt = IDLE;
        term_nxt = half_period;
      end else if (st == IDLE && accept) st_nxt = ARMED;
      else if (st == ARMED && hit) begin
        st_nxt = APPLY;
        term_nxt = dir ? half_period + eff : half_period - eff;
      end else if (st == APPLY && hit) st_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        st <= IDLE;
        cnt <= '0;
        term <= H_DEF;
        mod <= 1'b0;
        dir <= 1'b0;
        step <= '0;
      end else begin
        st <= st_nxt;
        term <= term_nxt;
        cnt <= sync_req || hit ? '0 : cnt + CNT_W'(1);
        mod <= !sync_req && (mod ^ hit);
        if (accept) begin
          dir <= cmd_dir;
          step <= cmd_step;
        end
      end
`ifdef PHASE_TRACK_EN
    // effective step is frozen when the modified terminal is loaded, so a later base change cannot skew it
    logic [CNT_W-1:0] eff_q;
    logic [CNT_W+1:0] acc;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        eff_q <= '0;
        acc <= '0;
      end else begin
        if (st == ARMED && hit) eff_q <= eff;
        if (sync_req) acc <= '0;
        else if (shift_done[c]) acc <= dir ? acc + (CNT_W+2)'(eff_q) : acc - (CNT_W+2)'(eff_q);
      end
    assign phase_acc[c*(CNT_W+2) +: CNT_W+2] = acc;
`else
    assign phase_acc[c*(CNT_W+2) +: CNT_W+2] = '0;
`endif
  end
endmodule

// File: tb/tb_phase_shift_gen.sv
// tb_phase_shift_gen: directed checks of base rate, delay/advance shifts, saturation, command gating, sync and reset.
module tb_phase_shift_gen;
  localparam int AW = 18;
`ifdef PHASE_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic [15:0] half_period = 16'd4;
  logic sync_req = 0, cmd_valid = 0, cmd_dir = 0, cmd_ch = 0, cmd_ready;
  logic [15:0] cmd_step = 0;
  logic [1:0] mod_out, shift_done;
  logic [2*AW-1:0] phase_acc;
  logic [7:0] s_half = 8'd250, s_step = 0;
  logic s_sync = 0, s_valid = 0, s_ch = 0, s_dir = 0, s_ready;
  logic [0:0] s_mod, s_done;
  logic [9:0] s_acc;
  int tests = 0, fails = 0, done0 = 0, done1 = 0, done_s = 0;

  phase_shift_gen #(.N_CH(2), .CNT_W(16), .STEP_W(16), .HALF_PERIOD_DEF(4)) u_dut (
    .clk(clk), .rst(rst), .half_period(half_period), .sync_req(sync_req), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .cmd_step(cmd_step),
    .mod_out(mod_out), .shift_done(shift_done), .phase_acc(phase_acc));

  phase_shift_gen #(.N_CH(1), .CNT_W(8), .STEP_W(8), .HALF_PERIOD_DEF(250)) u_sat (
    .clk(clk), .rst(rst), .half_period(s_half), .sync_req(s_sync), .cmd_valid(s_valid),
    .cmd_ready(s_ready), .cmd_ch(s_ch), .cmd_dir(s_dir), .cmd_step(s_step),
    .mod_out(s_mod), .shift_done(s_done), .phase_acc(s_acc));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (shift_done[0] === 1'b1) done0++;
    if (shift_done[1] === 1'b1) done1++;
    if (s_done[0] === 1'b1) done_s++;
  end

  function automatic logic mod_of(input int ch);
    return ch == 2 ? s_mod[0] : mod_out[ch];
  endfunction
  function automatic logic [AW-1:0] ex(input int v);
    return TRACK ? AW'(v) : '0;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic half_len(input int ch, output int n);
    logic v;
    v = mod_of(ch);
    n = 0;
    do begin
      tick();
      n++;
    end while (mod_of(ch) === v && n < 600);
  endtask
  task automatic send(input logic ch, input logic dir, input int step);
    cmd_valid = 1; cmd_ch = ch; cmd_dir = dir; cmd_step = 16'(step);
    tick();
    cmd_valid = 0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    tests++; if (mod_out !== 2'b00) begin fails++; $display("FAIL reset_mod: got %b expected 00", mod_out); end
    tests++; if (shift_done !== 2'b00) begin fails++; $display("FAIL reset_done: got %b expected 00", shift_done); end
    tests++; if (phase_acc !== '0) begin fails++; $display("FAIL reset_acc: got %h expected 0", phase_acc); end
    cmd_ch = 1; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready1: got %b expected 1", cmd_ready); end
    cmd_ch = 0; s_ch = 1; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready0: got %b expected 1", cmd_ready); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL ready_out_of_range: got %b expected 0", s_ready); end
    s_ch = 0; #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL sat_ready: got %b expected 1", s_ready); end
    tick();
    rst = 1;
  endtask

  task automatic test_base;
    int n;
    half_len(0, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL base_first: got %0d expected 5", n); end
    tests++; if (mod_out !== 2'b11) begin fails++; $display("FAIL base_inphase_hi: got %b expected 11", mod_out); end
    half_len(0, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL base_second: got %0d expected 5", n); end
    tests++; if (mod_out !== 2'b00) begin fails++; $display("FAIL base_inphase_lo: got %b expected 00", mod_out); end
  endtask

  task automatic test_delay;
    int n;
    send(0, 1, 2);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL delay_ready0: got %b expected 0", cmd_ready); end
    cmd_ch = 1; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL delay_ready1: got %b expected 1", cmd_ready); end
    half_len(0, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL delay_rest: got %0d expected 4", n); end
    half_len(0, n);
    tests++; if (n !== 7) begin fails++; $display("FAIL delay_stretched: got %0d expected 7", n); end
    half_len(1, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL delay_ch1_offset: got %0d expected 3", n); end
    half_len(0, n);
    tests++; if (n !== 2) begin fails++; $display("FAIL delay_ch0_back: got %0d expected 2", n); end
    tests++; if (done0 !== 1 || done1 !== 0) begin fails++; $display("FAIL delay_done: got %0d/%0d expected 1/0", done0, done1); end
    tests++; if (phase_acc[AW-1:0] !== ex(2)) begin fails++; $display("FAIL delay_acc0: got %h expected %h", phase_acc[AW-1:0], ex(2)); end
  endtask

  task automatic test_advance;
    int n;
    send(1, 0, 2);
    half_len(1, n);
    tests++; if (n !== 2) begin fails++; $display("FAIL adv_rest: got %0d expected 2", n); end
    half_len(1, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL adv_short: got %0d expected 3", n); end
    half_len(1, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL adv_back: got %0d expected 5", n); end
    tests++; if (phase_acc[2*AW-1:AW] !== ex(-2)) begin fails++; $display("FAIL adv_acc1: got %h expected %h", phase_acc[2*AW-1:AW], ex(-2)); end
    send(1, 0, 10);
    half_len(1, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL clamp_rest: got %0d expected 4", n); end
    half_len(1, n);
    tests++; if (n !== 1) begin fails++; $display("FAIL clamp_min: got %0d expected 1", n); end
    half_len(1, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL clamp_back: got %0d expected 5", n); end
    tests++; if (done1 !== 2) begin fails++; $display("FAIL clamp_done1: got %0d expected 2", done1); end
    tests++; if (phase_acc[2*AW-1:AW] !== ex(-6)) begin fails++; $display("FAIL clamp_acc1: got %h expected %h", phase_acc[2*AW-1:AW], ex(-6)); end
  endtask

  task automatic test_back_to_back;
    int n;
    send(0, 1, 1);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_armed_ready0: got %b expected 0", cmd_ready); end
    cmd_valid = 1; cmd_ch = 1; cmd_dir = 1; cmd_step = 16'd3; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b expected 1", cmd_ready); end
    tick();
    cmd_ch = 0; cmd_dir = 0; cmd_step = 16'd3; #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_reject0: got %b expected 0", cmd_ready); end
    tick();
    cmd_valid = 0; #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_apply_ready0: got %b expected 0", cmd_ready); end
    half_len(0, n);
    tests++; if (n !== 6) begin fails++; $display("FAIL b2b_ch0: got %0d expected 6", n); end
    half_len(1, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL b2b_ch1: got %0d expected 4", n); end
    half_len(0, n);
    tests++; if (n !== 1) begin fails++; $display("FAIL b2b_gap: got %0d expected 1", n); end
    half_len(1, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL b2b_ch1_back: got %0d expected 4", n); end
    tests++; if (done0 !== 2 || done1 !== 3) begin fails++; $display("FAIL b2b_done: got %0d/%0d expected 2/3", done0, done1); end
    tests++; if (phase_acc !== {ex(-3), ex(3)}) begin fails++; $display("FAIL b2b_acc: got %h expected %h", phase_acc, {ex(-3), ex(3)}); end
  endtask

  task automatic test_sync;
    int n, d0, d1;
    send(0, 1, 2);
    sync_req = 1;
    tick();
    sync_req = 0; cmd_ch = 0; #1;
    d0 = done0; d1 = done1;
    tests++; if (mod_out !== 2'b00) begin fails++; $display("FAIL sync_mod: got %b expected 00", mod_out); end
    tests++; if (phase_acc !== '0) begin fails++; $display("FAIL sync_acc: got %h expected 0", phase_acc); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL sync_ready: got %b expected 1", cmd_ready); end
    half_len(0, n);
    tests++; if (n !== 5 || mod_out !== 2'b11) begin fails++; $display("FAIL sync_realign: got %0d/%b expected 5/11", n, mod_out); end
    half_len(0, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL sync_dropped: got %0d expected 5", n); end
    tests++; if (done0 !== d0 || done1 !== d1) begin fails++; $display("FAIL sync_no_done: got %0d/%0d expected %0d/%0d", done0, done1, d0, d1); end
  endtask

  task automatic test_reset_mid;
    int n, d0;
    send(0, 1, 4);
    half_len(0, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL rmid_rest: got %0d expected 4", n); end
    tick(); tick();
    d0 = done0;
    rst = 0; #1;
    tests++; if (mod_out !== 2'b00 || shift_done !== 2'b00) begin fails++; $display("FAIL rmid_outs: got %b/%b expected 00/00", mod_out, shift_done); end
    tests++; if (phase_acc !== '0) begin fails++; $display("FAIL rmid_acc: got %h expected 0", phase_acc); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b expected 1", cmd_ready); end
    tick(); tick();
    rst = 1;
    half_len(0, n);
    tests++; if (n !== 5 || mod_out !== 2'b11) begin fails++; $display("FAIL rmid_restart: got %0d/%b expected 5/11", n, mod_out); end
    half_len(0, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL rmid_dropped: got %0d expected 5", n); end
    tests++; if (done0 !== d0) begin fails++; $display("FAIL rmid_no_done: got %0d expected %0d", done0, d0); end
  endtask

  task automatic test_base_change;
    int n;
    tick(); tick();
    half_period = 16'd6;
    half_len(0, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL hchg_current: got %0d expected 3", n); end
    half_len(0, n);
    tests++; if (n !== 7) begin fails++; $display("FAIL hchg_new: got %0d expected 7", n); end
    half_period = 16'd4;
    half_len(0, n);
    tests++; if (n !== 7) begin fails++; $display("FAIL hchg_loaded: got %0d expected 7", n); end
    half_len(0, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL hchg_restore: got %0d expected 5", n); end
  endtask

  task automatic test_saturation;
    int n;
    s_sync = 1;
    tick();
    s_sync = 0;
    half_len(2, n);
    tests++; if (n !== 251 || s_mod !== 1'b1) begin fails++; $display("FAIL sat_base: got %0d/%b expected 251/1", n, s_mod); end
    s_valid = 1; s_ch = 0; s_dir = 1; s_step = 8'd10;
    tick();
    s_valid = 0;
    half_len(2, n);
    tests++; if (n !== 250) begin fails++; $display("FAIL sat_rest: got %0d expected 250", n); end
    half_len(2, n);
    tests++; if (n !== 256) begin fails++; $display("FAIL sat_stretched: got %0d expected 256", n); end
    half_len(2, n);
    tests++; if (n !== 251) begin fails++; $display("FAIL sat_back: got %0d expected 251", n); end
    tests++; if (done_s !== 1) begin fails++; $display("FAIL sat_done: got %0d expected 1", done_s); end
    tests++; if (s_acc !== 10'(TRACK ? 5 : 0)) begin fails++; $display("FAIL sat_acc: got %0d expected %0d", s_acc, TRACK ? 5 : 0); end
  endtask

  initial begin
    test_reset();
    test_base();
    test_delay();
    test_advance();
    test_back_to_back();
    test_sync();
    test_reset_mid();
    test_base_change();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
